// File: rtl/mux_demux_comportamental_pkg.sv
// rtl/mux_demux_comportamental_pkg.sv - shared parameters and helpers for the mux/demux link
package mux_demux_comportamental_pkg;

  localparam int N_CH_DEFAULT = 4;
  localparam int W_DEFAULT    = 1;

  // Select width for n channels; same result as $clog2(n)
  function automatic int sel_w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Lowest bit index of channel ch in a packed word of w-bit channels
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/mux_demux_comportamental_demux_stage.sv
// rtl/mux_demux_comportamental_demux_stage.sv - registered 1-to-N channel demultiplexer
module demux_stage
  import mux_demux_comportamental_pkg::*;
#(
  parameter int  N_CH  = N_CH_DEFAULT,
  parameter int  W     = W_DEFAULT,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [W-1:0]      link_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [N_CH*W-1:0] y_o,
  output logic              valid_o
);

  logic [N_CH*W-1:0] y_d;
  logic [N_CH*W-1:0] y_q;
  logic              valid_q;

  // Place the link value in its channel slot; all other slots (and bad codes) are zero
  always_comb begin
    y_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(sel_i) == c) y_d[ch_lsb(c, W) +: W] = link_i;
    end
  end

  // Update the output word only on a valid link beat, otherwise hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_i) y_q <= y_d;
      valid_q <= valid_i;
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mux_demux_comportamental_mux_stage.sv
// rtl/mux_demux_comportamental_mux_stage.sv - registered 1-of-N channel multiplexer
module mux_stage
  import mux_demux_comportamental_pkg::*;
#(
  parameter int  N_CH  = N_CH_DEFAULT,
  parameter int  W     = W_DEFAULT,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [N_CH*W-1:0] d_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [W-1:0]      link_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              valid_o
);

  logic [W-1:0]     link_d;
  logic [W-1:0]     link_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;

  // Pick the selected channel; a code with no matching channel yields zero
  always_comb begin
    link_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(sel_i) == c) link_d = d_i[ch_lsb(c, W) +: W];
    end
  end

  // Capture data and select together so the next stage never mixes cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      link_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_i) begin
        link_q <= link_d;
        sel_q  <= sel_i;
      end
      valid_q <= valid_i;
    end
  end

  assign link_o  = link_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mux_demux_comportamental.sv
// rtl/mux_demux_comportamental.sv - two-stage select-and-route-back link top level
module mux_demux_comportamental
  import mux_demux_comportamental_pkg::*;
#(
  parameter int  N_CH  = N_CH_DEFAULT,
  parameter int  W     = W_DEFAULT,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [N_CH*W-1:0] d_i,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      link_o,
  output logic              link_valid,
  output logic [N_CH*W-1:0] y_o,
  output logic              y_valid
);

  logic [SEL_W-1:0] sel_q;

  mux_stage #(.N_CH(N_CH), .W(W)) u_mux (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (in_valid),
    .d_i     (d_i),
    .sel_i   (sel),
    .link_o  (link_o),
    .sel_o   (sel_q),
    .valid_o (link_valid)
  );

  demux_stage #(.N_CH(N_CH), .W(W)) u_demux (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (link_valid),
    .link_i  (link_o),
    .sel_i   (sel_q),
    .y_o     (y_o),
    .valid_o (y_valid)
  );

endmodule

// File: tb/tb_mux_demux_comportamental.sv
// tb/tb_mux_demux_comportamental.sv - scoreboard bench for the mux/demux link
module tb_mux_demux_comportamental;

  typedef struct {
    logic [31:0] val;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [3:0]  d0 = '0;
  logic [31:0] d1 = '0;
  logic [2:0]  d2 = '0;
  logic [1:0]  s0 = '0, s1 = '0, s2 = '0;

  logic        l0, lv0, yv0;
  logic [3:0]  y0;
  logic [7:0]  l1;
  logic        lv1, yv1;
  logic [31:0] y1;
  logic        l2, lv2, yv2;
  logic [2:0]  y2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t        lq[3][$];
  exp_t        yq[3][$];
  logic [31:0] last_l[3];
  logic [31:0] last_y[3];

  mux_demux_comportamental #(.N_CH(4), .W(1)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .d_i(d0), .sel(s0),
    .link_o(l0), .link_valid(lv0), .y_o(y0), .y_valid(yv0)
  );

  mux_demux_comportamental #(.N_CH(4), .W(8)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .d_i(d1), .sel(s1),
    .link_o(l1), .link_valid(lv1), .y_o(y1), .y_valid(yv1)
  );

  mux_demux_comportamental #(.N_CH(3), .W(1)) u_np2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .d_i(d2), .sel(s2),
    .link_o(l2), .link_valid(lv2), .y_o(y2), .y_valid(yv2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Compare one instance's outputs against the front of its expectation queues
  task automatic mon(input int i, input logic lv, input logic [31:0] l,
                     input logic yv, input logic [31:0] y);
    exp_t e;
    logic exp_lv, exp_yv;
    exp_lv = (lq[i].size() > 0) && (lq[i][0].stamp == cyc);
    exp_yv = (yq[i].size() > 0) && (yq[i][0].stamp == cyc);
    chk($sformatf("inst%0d link_valid", i), {31'b0, lv}, {31'b0, exp_lv});
    if (exp_lv) begin
      e = lq[i].pop_front();
      chk($sformatf("inst%0d link_o", i), l, e.val);
      last_l[i] = e.val;
    end else begin
      chk($sformatf("inst%0d link_o hold", i), l, last_l[i]);
    end
    chk($sformatf("inst%0d y_valid", i), {31'b0, yv}, {31'b0, exp_yv});
    if (exp_yv) begin
      e = yq[i].pop_front();
      chk($sformatf("inst%0d y_o", i), y, e.val);
      last_y[i] = e.val;
    end else begin
      chk($sformatf("inst%0d y_o hold", i), y, last_y[i]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, lv0, {31'b0, l0}, yv0, {28'b0, y0});
    mon(1, lv1, {24'b0, l1}, yv1, y1);
    mon(2, lv2, {31'b0, l2}, yv2, {29'b0, y2});
  end

  // One cycle of stimulus on instance i; expected link/y are hand-computed by the caller
  task automatic drive(input int i, input logic v, input logic [31:0] d, input logic [1:0] s,
                       input logic [31:0] el, input logic [31:0] ey);
    exp_t e;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    case (i)
      0: begin v0 = v; d0 = d[3:0]; s0 = s; end
      1: begin v1 = v; d1 = d;      s1 = s; end
      default: begin v2 = v; d2 = d[2:0]; s2 = s; end
    endcase
    if (v) begin
      e.val = el; e.stamp = cyc + 1; lq[i].push_back(e);
      e.val = ey; e.stamp = cyc + 2; yq[i].push_back(e);
    end
  endtask

  // Assert reset between clock edges and check every output clears at once
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    #1;
    chk("rst link_o",     {31'b0, l0},  32'h0);
    chk("rst link_valid", {31'b0, lv0}, 32'h0);
    chk("rst y_o",        {28'b0, y0},  32'h0);
    chk("rst y_valid",    {31'b0, yv0}, 32'h0);
    chk("rst wide y_o",   y1,           32'h0);
    chk("rst np2 y_o",    {29'b0, y2},  32'h0);
    for (int i = 0; i < 3; i++) begin
      lq[i].delete();
      yq[i].delete();
      last_l[i] = '0;
      last_y[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] sw_l;
    logic [3:0] sw_y[4];
    logic [3:0] bb_sel[4];
    logic [3:0] bb_y[4];
    sw_l = 4'b1010;
    sw_y = '{4'b0000, 4'b0010, 4'b0000, 4'b1000};
    bb_sel = '{4'd3, 4'd0, 4'd2, 4'd1};
    bb_y = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      last_l[i] = '0;
      last_y[i] = '0;
    end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sweep every select on 1010, four cycles each
    for (int s = 0; s < 4; s++)
      repeat (4) drive(0, 1'b1, 32'hA, 2'(s), {31'b0, sw_l[s]}, {28'b0, sw_y[s]});

    // Select changes every cycle on all-ones data
    for (int k = 0; k < 4; k++)
      drive(0, 1'b1, 32'hF, bb_sel[k][1:0], 32'h1, {28'b0, bb_y[k]});

    // Valid gap with toggling inputs, then one more transfer
    drive(0, 1'b0, 32'h5, 2'd0, 32'h0, 32'h0);
    drive(0, 1'b0, 32'hA, 2'd3, 32'h0, 32'h0);
    drive(0, 1'b0, 32'h6, 2'd1, 32'h0, 32'h0);
    drive(0, 1'b1, 32'h4, 2'd2, 32'h1, 32'h4);

    // Wide channels
    drive(1, 1'b1, 32'hDDCCBBAA, 2'd2, 32'hCC, 32'h00CC0000);
    drive(1, 1'b1, 32'hDDCCBBAA, 2'd0, 32'hAA, 32'h000000AA);
    drive(1, 1'b1, 32'hDDCCBBAA, 2'd3, 32'hDD, 32'hDD000000);

    // Three channels: code 3 has no channel
    drive(2, 1'b1, 32'h5, 2'd2, 32'h1, 32'h4);
    drive(2, 1'b1, 32'h5, 2'd3, 32'h0, 32'h0);
    drive(2, 1'b1, 32'h5, 2'd0, 32'h1, 32'h1);
    drive(2, 1'b0, 32'h0, 2'd0, 32'h0, 32'h0);
    drive(2, 1'b0, 32'h0, 2'd0, 32'h0, 32'h0);

    // Reset with two transfers still in flight
    drive(0, 1'b1, 32'hF, 2'd1, 32'h1, 32'h2);
    drive(0, 1'b1, 32'hF, 2'd3, 32'h1, 32'h8);
    mid_reset();

    // Recovery after reset
    drive(0, 1'b1, 32'h1, 2'd0, 32'h1, 32'h1);
    drive(0, 1'b0, 32'h0, 2'd0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("inst%0d link queue drained", i), 32'(lq[i].size()), 32'h0);
      chk($sformatf("inst%0d y queue drained", i), 32'(yq[i].size()), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
